// File: rtl/modred_pkg.sv
// modred_pkg: shared types and constants for the modular-reduction scheduler.
package modred_pkg;
   localparam int DATA_LENGTH = 64;
   localparam int KYBER_Q = 3329;
   localparam int DILITHIUM_Q = 8380417;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, RECOVER} sched_state_t;
endpackage

// File: rtl/modred_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching cyclically from last_i+1.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    last_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o
);
   logic found;
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (en_i && !found && req_i[(int'(last_i) + i) % NUM_REQ]) begin
            found = 1'b1;
            gnt_o[(int'(last_i) + i) % NUM_REQ] = 1'b1;
            idx_o = ID_W'((int'(last_i) + i) % NUM_REQ);
         end
      end
   end
endmodule

// File: rtl/modred_scheduler.sv
// modred_scheduler: shares one serial modular reducer between NUM_REQ requesters,
// round-robin granted, with a watchdog that resets a reducer that never finishes.
module modred_scheduler
   import modred_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_LENGTH = modred_pkg::DATA_LENGTH,
   parameter int ID_W = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   input  logic [NUM_REQ*DATA_LENGTH-1:0] req_x_i,
   input  logic [NUM_REQ*DATA_LENGTH-1:0] req_m_i,
   input  logic [NUM_REQ*DATA_LENGTH-1:0] req_m_bl_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [ID_W-1:0]                rsp_id_o,
   output logic [DATA_LENGTH-1:0]         rsp_result_o,
   output logic                           rsp_err_o,
   output logic                           busy_o,
   output logic                           red_rst_no,
   output logic                           red_start_o,
   output logic [DATA_LENGTH-1:0]         red_x_o,
   output logic [DATA_LENGTH-1:0]         red_m_o,
   output logic [DATA_LENGTH-1:0]         red_m_bl_o,
   input  logic [DATA_LENGTH-1:0]         red_result_i,
   input  logic                           red_valid_i
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   sched_state_t state_q, state_d;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0] gidx, last_q, id_q;
   logic [DATA_LENGTH-1:0] x_q, m_q, bl_q, res_q;
   logic err_q, wd_clear_q, timeout;
   logic [WD_W-1:0] wd_q;

   assign timeout = wd_q == WD_W'(TIMEOUT_CYCLES - 1);

   // reset is folded into the enable so no grant is offered while rst_i is held
   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req_i  (req_valid_i),
      .last_i (last_q),
      .en_i   (state_q == IDLE && !rst_i),
      .gnt_o  (gnt),
      .idx_o  (gidx)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = |gnt ? ISSUE : IDLE;
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = red_valid_i ? RESP : (timeout ? RECOVER : WAIT);
         RECOVER: state_d = RESP;
         RESP:    state_d = rsp_ready_i ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         last_q     <= ID_W'(NUM_REQ - 1);
         id_q       <= '0;
         x_q        <= '0;
         m_q        <= '0;
         bl_q       <= '0;
         res_q      <= '0;
         err_q      <= 1'b0;
         wd_q       <= '0;
         wd_clear_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wd_q       <= state_q == WAIT ? wd_q + 1'b1 : '0;
         wd_clear_q <= state_q == WAIT && !red_valid_i && timeout;
         if (state_q == IDLE && |gnt) begin
            x_q    <= req_x_i[int'(gidx)*DATA_LENGTH +: DATA_LENGTH];
            m_q    <= req_m_i[int'(gidx)*DATA_LENGTH +: DATA_LENGTH];
            bl_q   <= req_m_bl_i[int'(gidx)*DATA_LENGTH +: DATA_LENGTH];
            id_q   <= gidx;
            last_q <= gidx;
         end
         if (state_q == WAIT && red_valid_i) begin
            res_q <= red_result_i;
            err_q <= 1'b0;
         end else if (state_q == WAIT && timeout) begin
            res_q <= '0;
            err_q <= 1'b1;
         end
      end
   end

   assign req_ready_o  = gnt;
   assign busy_o       = state_q != IDLE;
   assign red_rst_no   = ~(rst_i | wd_clear_q);
   assign red_start_o  = state_q == ISSUE;
   assign red_x_o      = x_q;
   assign red_m_o      = m_q;
   assign red_m_bl_o   = bl_q;
   assign rsp_valid_o  = state_q == RESP;
   assign rsp_id_o     = id_q;
   assign rsp_result_o = res_q;
   assign rsp_err_o    = err_q;
endmodule

// File: tb/tb_modred_scheduler.sv
// tb_modred_scheduler: randomized and directed scoreboard bench for modred_scheduler
// with a behavioural reducer stub.
module tb_modred_scheduler;
   import modred_pkg::*;
   localparam int N = 4;
   localparam int DL = 64;
   localparam int TO = 64;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic [N-1:0] req_valid_i = '0;
   logic [N-1:0] req_ready_o;
   logic [N*DL-1:0] req_x_i = '0, req_m_i = '0, req_m_bl_i = '0;
   logic rsp_valid_o, rsp_err_o, busy_o, red_rst_no, red_start_o;
   logic rsp_ready_i = 1'b1;
   logic [1:0] rsp_id_o;
   logic [DL-1:0] rsp_result_o, red_x_o, red_m_o, red_m_bl_o;
   logic [DL-1:0] red_result_i = '0;
   logic red_valid_i = 1'b0;

   always #5 clk_i = ~clk_i;

   modred_scheduler #(.NUM_REQ(N), .DATA_LENGTH(DL), .ID_W(2), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_x_i(req_x_i), .req_m_i(req_m_i), .req_m_bl_i(req_m_bl_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
      .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
      .red_rst_no(red_rst_no), .red_start_o(red_start_o), .red_x_o(red_x_o),
      .red_m_o(red_m_o), .red_m_bl_o(red_m_bl_o), .red_result_i(red_result_i),
      .red_valid_i(red_valid_i)
   );

   typedef struct {
      int id;
      logic [63:0] x, m, bl, res;
      bit err;
   } txn_t;

   txn_t exp_q[$], rsp_log[$];
   txn_t cur, e, a;
   int grant_log[$];
   int checks = 0, errors = 0;
   int ptr = N - 1, since = 0, rst_low = 0, first_since = -1, starts = 0, g;
   bit inflight = 0, was = 0, prev_rv = 0, stable_prev = 0, hang = 0;
   int lat_fix = 0;
   logic [1:0] pid;
   logic [63:0] pres;
   logic perr;
   logic [N-1:0] acc_vec = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int i = 1; i <= N; i++)
         if (v[(last + i) % N]) return (last + i) % N;
      return -1;
   endfunction

   function automatic logic [63:0] bitlen(input logic [63:0] m);
      for (int i = 63; i >= 0; i--)
         if (m[i]) return 64'(i + 1);
      return 64'd0;
   endfunction

   // reducer stub: answers x mod m a few cycles after start, unless told to hang
   int cnt = 0;
   logic [63:0] sx, sm, sbl;
   always @(posedge clk_i) begin
      #1;
      red_valid_i = 1'b0;
      if (!red_rst_no) cnt = 0;
      else if (red_start_o) begin
         cnt = lat_fix > 0 ? lat_fix : int'($urandom_range(1, 6));
         sx = red_x_o;
         sm = red_m_o;
         sbl = red_m_bl_o;
      end else if (cnt > 0) begin
         cnt--;
         if (cnt == 0 && !hang) begin
            red_valid_i = 1'b1;
            red_result_i = (sm != 0 && sbl == bitlen(sm)) ? sx % sm : 64'hBAD;
         end
      end
   end

   // monitor / scoreboard
   always @(negedge clk_i) begin
      if (rst_i) begin
         chk("rst_ready", 64'(req_ready_o), 0);
         chk("rst_rsp_valid", 64'(rsp_valid_o), 0);
         chk("rst_busy", 64'(busy_o), 0);
         chk("rst_start", 64'(red_start_o), 0);
         chk("rst_red_rst_no", 64'(red_rst_no), 0);
         chk("rst_result", rsp_result_o, 0);
         chk("rst_red_x", red_x_o, 0);
         exp_q.delete();
         inflight = 0;
         ptr = N - 1;
         prev_rv = 0;
         stable_prev = 0;
         acc_vec = '0;
      end else begin
         was = inflight;
         chk("busy", 64'(busy_o), 64'(was));
         if (was) begin
            since++;
            chk("ready_while_busy", 64'(req_ready_o), 0);
            chk("start_pulse", 64'(red_start_o), 64'(since == 1));
            if (red_start_o) starts++;
            if (since == 1) begin
               chk("red_x", red_x_o, cur.x);
               chk("red_m", red_m_o, cur.m);
               chk("red_bl", red_m_bl_o, cur.bl);
            end
            if (prev_rv) chk("rsp_after_red_valid", 64'(rsp_valid_o), 1);
            prev_rv = red_valid_i;
            if (!red_rst_no) rst_low++;
            if (stable_prev) begin
               chk("hold_valid", 64'(rsp_valid_o), 1);
               chk("hold_id", 64'(rsp_id_o), 64'(pid));
               chk("hold_result", rsp_result_o, pres);
               chk("hold_err", 64'(rsp_err_o), 64'(perr));
            end
            stable_prev = rsp_valid_o && !rsp_ready_i;
            pid = rsp_id_o;
            pres = rsp_result_o;
            perr = rsp_err_o;
            if (rsp_valid_o && first_since < 0) first_since = since;
            if (rsp_valid_o && rsp_ready_i) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rsp id %0d result %0h", rsp_id_o, rsp_result_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_id", 64'(rsp_id_o), 64'(e.id));
                  chk("rsp_result", rsp_result_o, e.res);
                  chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
                  chk("red_rst_pulses", 64'(rst_low), 64'(e.err));
                  if (e.err) chk("timeout_latency", 64'(first_since), 64'(TO + 3));
               end
               a.id = int'(rsp_id_o);
               a.res = rsp_result_o;
               a.err = rsp_err_o;
               rsp_log.push_back(a);
               inflight = 0;
            end
         end else begin
            g = rr_pick(req_valid_i, ptr);
            chk("grant", 64'(req_ready_o), g < 0 ? 64'd0 : 64'(1) << g);
            if (g >= 0) begin
               cur.id = g;
               cur.x = req_x_i[g*DL +: DL];
               cur.m = req_m_i[g*DL +: DL];
               cur.bl = req_m_bl_i[g*DL +: DL];
               cur.err = hang;
               cur.res = hang ? 64'd0 : cur.x % cur.m;
               exp_q.push_back(cur);
               grant_log.push_back(g);
               ptr = g;
               inflight = 1;
               since = 0;
               rst_low = 0;
               first_since = -1;
               prev_rv = 0;
               stable_prev = 0;
            end
         end
         acc_vec = req_valid_i & req_ready_o;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
      req_valid_i = req_valid_i & ~acc_vec;
   endtask

   task automatic set_req(input int k, input logic [63:0] x, input logic [63:0] m, input logic [63:0] bl);
      req_x_i[k*DL +: DL] = x;
      req_m_i[k*DL +: DL] = m;
      req_m_bl_i[k*DL +: DL] = bl;
      req_valid_i[k] = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((inflight || exp_q.size() != 0 || req_valid_i != 0) && n < budget) begin
         tick();
         n++;
      end
      if (inflight || exp_q.size() != 0 || req_valid_i != 0) begin
         checks++;
         errors++;
         $display("FAIL idle_wait still busy after %0d cycles", budget);
      end
   endtask

   task automatic check_rsp(input int i, input int id, input logic [63:0] res, input bit err);
      if (i < rsp_log.size()) begin
         chk("log_id", 64'(rsp_log[i].id), 64'(id));
         chk("log_result", rsp_log[i].res, res);
         chk("log_err", 64'(rsp_log[i].err), 64'(err));
      end else chk("log_missing", 64'(rsp_log.size()), 64'(i + 1));
   endtask

   task automatic clear_logs();
      rsp_log.delete();
      grant_log.delete();
   endtask

   initial begin
      logic [63:0] rm;
      int n;
      repeat (3) tick();
      rst_i = 1'b0;
      // all four contend: grants 0,1,2,3
      clear_logs();
      for (int k = 0; k < N; k++) set_req(k, 64'd100000, 64'd8191, 64'd13);
      wait_idle(200);
      chk("t2_grants", 64'(grant_log.size()), 4);
      for (int i = 0; i < grant_log.size() && i < 4; i++) chk("t2_order", 64'(grant_log[i]), 64'(i));
      for (int i = 0; i < 4; i++) check_rsp(i, i, 64'd1708, 1'b0);
      // single Kyber request on requester 2
      clear_logs();
      starts = 0;
      set_req(2, 64'd10000, 64'(KYBER_Q), 64'd12);
      wait_idle(100);
      chk("t1_starts", 64'(starts), 1);
      check_rsp(0, 2, 64'd13, 1'b0);
      // response backpressure with another requester waiting
      clear_logs();
      rsp_ready_i = 1'b0;
      set_req(1, 64'd5000, 64'(KYBER_Q), 64'd12);
      tick();
      tick();
      set_req(3, 64'd7000, 64'(KYBER_Q), 64'd12);
      n = 0;
      while (!rsp_valid_o && n < 50) begin
         tick();
         n++;
      end
      repeat (10) tick();
      chk("t3_held", 64'(rsp_valid_o), 1);
      rsp_ready_i = 1'b1;
      wait_idle(100);
      check_rsp(0, 1, 64'd1671, 1'b0);
      check_rsp(1, 3, 64'd342, 1'b0);
      // hung reducer, then a normal transaction
      clear_logs();
      hang = 1;
      set_req(0, 64'd12345, 64'(KYBER_Q), 64'd12);
      wait_idle(200);
      hang = 0;
      set_req(0, 64'd12345, 64'(KYBER_Q), 64'd12);
      wait_idle(100);
      check_rsp(0, 0, 64'd0, 1'b1);
      check_rsp(1, 0, 64'd2358, 1'b0);
      // reset while waiting on the reducer
      clear_logs();
      lat_fix = 20;
      set_req(1, 64'd777, 64'd100, 64'd7);
      repeat (5) tick();
      chk("t5_busy_before", 64'(busy_o), 1);
      rst_i = 1'b1;
      #1;
      chk("t5_async_busy", 64'(busy_o), 0);
      chk("t5_async_red_rst_no", 64'(red_rst_no), 0);
      chk("t5_async_start", 64'(red_start_o), 0);
      tick();
      tick();
      rst_i = 1'b0;
      lat_fix = 0;
      clear_logs();
      set_req(3, 64'd400, 64'd100, 64'd7);
      set_req(0, 64'd401, 64'd100, 64'd7);
      wait_idle(100);
      chk("t5_grants", 64'(grant_log.size()), 2);
      if (grant_log.size() > 0) chk("t5_first", 64'(grant_log[0]), 0);
      check_rsp(0, 0, 64'd1, 1'b0);
      check_rsp(1, 3, 64'd0, 1'b0);
      // Dilithium with requester 1 churning its inputs while 0 is served
      clear_logs();
      lat_fix = 8;
      set_req(0, 64'd8380418, 64'(DILITHIUM_Q), 64'd23);
      tick();
      for (int i = 0; i < 6; i++) begin
         req_x_i[DL +: DL] = {$urandom, $urandom};
         req_m_i[DL +: DL] = 64'($urandom);
         req_valid_i[1] = 1'($urandom_range(0, 1));
         tick();
      end
      set_req(1, 64'd20000000, 64'(DILITHIUM_Q), 64'd23);
      lat_fix = 0;
      wait_idle(100);
      check_rsp(0, 0, 64'd1, 1'b0);
      check_rsp(1, 1, 64'd3239166, 1'b0);
      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < N; k++) begin
            if (!req_valid_i[k] && $urandom_range(0, 3) == 0) begin
               rm = $urandom_range(0, 1) ? 64'($urandom_range(1, 9000)) : 64'({$urandom} | 32'h1);
               set_req(k, {$urandom, $urandom}, rm, bitlen(rm));
            end else if (req_valid_i[k] && $urandom_range(0, 19) == 0) req_valid_i[k] = 1'b0;
         end
         rsp_ready_i = $urandom_range(0, 3) != 0;
         tick();
      end
      rsp_ready_i = 1'b1;
      wait_idle(500);
      chk("final_queue_empty", 64'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout reached at %0t", $time);
      $fatal(1);
   end
endmodule
